// File: rtl/pc_fetch_ctrl.sv
// PC owner and instruction-fetch sequencer: issues req/ack fetches to the IROM, holds one
// instruction for execute, applies next-PC on retire and drops in-flight fetches on flush.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic        cpu_clk_i,
    input  logic        cpu_rst_i,
    input  logic        halt_i,
    output logic        irom_req_o,
    output logic [31:0] irom_addr_o,
    input  logic        irom_ack_i,
    input  logic [31:0] irom_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i,
    input  logic        npc_taken_i,
    input  logic [31:0] npc_target_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic [31:0] retire_cnt_o,
    output logic        adef_err_o
);

    typedef enum logic [1:0] {StIdle, StFetch, StDrop, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] saved_pc_q, saved_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        adef_q, adef_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] flush_al, target_al;

    assign flush_al  = {flush_pc_i[31:2], 2'b00};
    assign target_al = {npc_target_i[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        saved_pc_d = saved_pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        cnt_d      = cnt_q;
        adef_d     = adef_q;
        // Every accepted flush loads its target somewhere, so alignment is checked up front.
        if (flush_i && (flush_pc_i[1:0] != 2'b00)) adef_d = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (flush_i) fetch_pc_d = flush_al;
                if (!halt_i) state_d = StFetch;
            end
            StFetch: begin
                if (irom_ack_i) begin
                    if (flush_i) begin
                        fetch_pc_d = flush_al;
                    end else begin
                        inst_d    = irom_rdata_i;
                        inst_pc_d = fetch_pc_q;
                        state_d   = StHold;
                    end
                end else if (flush_i) begin
                    // Address must stay put until the IROM acks, so park the target.
                    saved_pc_d = flush_al;
                    state_d    = StDrop;
                end
            end
            StDrop: begin
                if (flush_i) saved_pc_d = flush_al;
                if (irom_ack_i) begin
                    fetch_pc_d = flush_i ? flush_al : saved_pc_q;
                    state_d    = StFetch;
                end
            end
            StHold: begin
                if (flush_i) begin
                    fetch_pc_d = flush_al;
                    state_d    = StFetch;
                end else if (inst_ready_i) begin
                    cnt_d = cnt_q + 32'd1;
                    if (npc_taken_i) begin
                        fetch_pc_d = target_al;
                        if (npc_target_i[1:0] != 2'b00) adef_d = 1'b1;
                    end else begin
                        fetch_pc_d = inst_pc_q + 32'd4;
                    end
                    state_d = halt_i ? StIdle : StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
        req_d   = (state_d == StFetch) || (state_d == StDrop);
        valid_d = (state_d == StHold);
        addr_d  = req_d ? fetch_pc_d : 32'd0;
    end

    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            saved_pc_q <= 32'd0;
            inst_q     <= 32'd0;
            inst_pc_q  <= 32'd0;
            cnt_q      <= 32'd0;
            adef_q     <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            addr_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            saved_pc_q <= saved_pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            cnt_q      <= cnt_d;
            adef_q     <= adef_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
        end
    end

    assign irom_req_o   = req_q;
    assign irom_addr_o  = addr_q;
    assign inst_valid_o = valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign retire_cnt_o = cnt_q;
    assign adef_err_o   = adef_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl: a random-latency IROM responder drives the DUT and a
// transaction-level reference model predicts every registered output each cycle.
module tb_pc_fetch_ctrl;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        halt;
    logic        irom_req;
    logic [31:0] irom_addr;
    logic        irom_ack;
    logic [31:0] irom_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        npc_taken;
    logic [31:0] npc_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] retire_cnt;
    logic        adef_err;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Reference model: a request is outstanding (busy), possibly stale (to be discarded),
    // or an instruction is being held.
    bit          m_busy, m_stale, m_hold, m_adef;
    logic [31:0] m_pc, m_saved, m_inst, m_ipc, m_cnt;

    bit          lat_active;
    int unsigned lat;

    pc_fetch_ctrl #(.RESET_PC(32'h1C00_0000)) dut (
        .cpu_clk_i    (cpu_clk),
        .cpu_rst_i    (cpu_rst),
        .halt_i       (halt),
        .irom_req_o   (irom_req),
        .irom_addr_o  (irom_addr),
        .irom_ack_i   (irom_ack),
        .irom_rdata_i (irom_rdata),
        .inst_valid_o (inst_valid),
        .inst_o       (inst),
        .inst_pc_o    (inst_pc),
        .inst_ready_i (inst_ready),
        .npc_taken_i  (npc_taken),
        .npc_target_i (npc_target),
        .flush_i      (flush),
        .flush_pc_i   (flush_pc),
        .retire_cnt_o (retire_cnt),
        .adef_err_o   (adef_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] align4(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] rand_target();
        int unsigned r = $urandom_range(0, 15);
        logic [31:0] t = 32'h1C00_0000 + ($urandom_range(0, 1023) << 2);
        if (r == 0) return 32'hFFFF_FFFC;
        if (r == 1) return t + $urandom_range(1, 3);
        return t;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_stale = 0; m_hold = 0; m_adef = 0;
        m_pc = 32'h1C00_0000; m_saved = 0; m_inst = 0; m_ipc = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        if (flush && flush_pc[1:0] != 2'b00) m_adef = 1;
        if (m_hold) begin
            if (flush) begin
                m_pc = align4(flush_pc); m_hold = 0; m_busy = 1;
            end else if (inst_ready) begin
                m_cnt = m_cnt + 1;
                if (npc_taken) begin
                    if (npc_target[1:0] != 2'b00) m_adef = 1;
                    m_pc = align4(npc_target);
                end else begin
                    m_pc = m_ipc + 4;
                end
                m_hold = 0;
                m_busy = !halt;
            end
        end else if (m_busy) begin
            if (irom_ack) begin
                if (m_stale) begin
                    m_pc = flush ? align4(flush_pc) : m_saved;
                    m_stale = 0;
                end else if (flush) begin
                    m_pc = align4(flush_pc);
                end else begin
                    m_inst = irom_rdata; m_ipc = m_pc; m_hold = 1; m_busy = 0;
                end
            end else if (flush) begin
                m_saved = align4(flush_pc);
                m_stale = 1;
            end
        end else begin
            if (flush) m_pc = align4(flush_pc);
            m_busy = !halt;
        end
    endtask

    task automatic compare_all();
        check_eq("irom_req", {31'd0, irom_req}, {31'd0, m_busy});
        check_eq("irom_addr", irom_addr, m_busy ? m_pc : 32'd0);
        check_eq("inst_valid", {31'd0, inst_valid}, {31'd0, m_hold});
        check_eq("inst", inst, m_inst);
        check_eq("inst_pc", inst_pc, m_ipc);
        check_eq("retire_cnt", retire_cnt, m_cnt);
        check_eq("adef_err", {31'd0, adef_err}, {31'd0, m_adef});
    endtask

    task automatic drive_inputs();
        irom_ack = 1'b0;
        if (irom_req) begin
            if (!lat_active) begin
                lat = $urandom_range(0, 3);
                lat_active = 1;
            end
            if (lat == 0) begin
                irom_ack = 1'b1;
                lat_active = 0;
            end else begin
                lat--;
            end
        end
        irom_rdata = $urandom;
        halt       = ($urandom_range(0, 7) == 0);
        inst_ready = ($urandom_range(0, 3) != 0);
        npc_taken  = ($urandom_range(0, 3) == 0);
        npc_target = rand_target();
        flush      = ($urandom_range(0, 9) == 0);
        flush_pc   = rand_target();
    endtask

    task automatic drive_idle();
        halt = 0; irom_ack = 0; irom_rdata = 0; inst_ready = 0;
        npc_taken = 0; npc_target = 0; flush = 0; flush_pc = 0;
    endtask

    initial begin
        cpu_rst = 1'b1;
        lat_active = 0;
        lat = 0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge cpu_clk);
        #1;
        compare_all();
        cpu_rst = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            drive_inputs();
            model_step();
            @(posedge cpu_clk);
            #1;
            compare_all();
            if (cyc == 2000) begin
                // Asynchronous reset mid-transaction: outputs must clear without a clock edge.
                cpu_rst = 1'b1;
                drive_idle();
                #1;
                model_reset();
                lat_active = 0;
                compare_all();
                @(posedge cpu_clk);
                #1;
                compare_all();
                cpu_rst = 1'b0;
            end
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
